rf_wport_arb: RTL and testbench

- Arbitrates the single GPR-file write port between the pipeline W stage and the multi-cycle mult/div unit. MD results go to a small FIFO, and each MD result can reach the register file at any time.
- Drains the FIFO into idle W slots and forces a slot when an entry starves.
- Gives decode busy flags for registers with a queued write, so decode can stall.
- Outputs are registered and drive the register file write port directly. The register file writes on the following negedge.

---
 rtl/rf_wport_arb.sv | 125 ++++++++++++
 tb/tb_rf_wport_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wport_arb.sv
// rf_wport_arb: shares the single GPR write port between the W stage and
// queued mult/div results. MD results wait in a small FIFO. They drain into
// idle W slots. A slot is forced for the queued head when it has waited too
// long, or when W targets a register that still has an older queued write.
module rf_wport_arb #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     md_valid,
    output logic                     md_ready,
    input  logic [4:0]               md_addr,
    input  logic [31:0]              md_data,
    output logic                     rf_we,
    output logic [4:0]               rf_a3,
    output logic [31:0]              rf_wd,
    input  logic [4:0]               q_a1,
    input  logic [4:0]               q_a2,
    output logic                     q_busy1,
    output logic                     q_busy2,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]       q_addr [DEPTH];
    logic [31:0]      q_data [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic [3:0]       starve;

    logic [DEPTH-1:0] entry_valid;
    logic [PW-1:0]    offs;
    logic             wb_hit;
    logic             fifo_empty;
    logic             wb_real;
    logic             force_md;
    logic             wb_sel;
    logic             pop;
    logic             push;

    assign fifo_count = count;

    // Entry validity by distance from the read pointer, and address matches
    // against every live entry (W conflict and decode busy flags).
    always_comb begin
        entry_valid = '0;
        offs        = '0;
        wb_hit      = 1'b0;
        q_busy1     = 1'b0;
        q_busy2     = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            offs           = PW'(i) - rd_ptr;
            entry_valid[i] = ({1'b0, offs} < count);
            if (entry_valid[i]) begin
                if (q_addr[i] == wb_addr) wb_hit  = 1'b1;
                if (q_addr[i] == q_a1)    q_busy1 = 1'b1;
                if (q_addr[i] == q_a2)    q_busy2 = 1'b1;
            end
        end
        if (q_a1 == 5'd0) q_busy1 = 1'b0;
        if (q_a2 == 5'd0) q_busy2 = 1'b0;
    end

    // Write-port grant: a forced MD pop beats W, W beats an opportunistic pop.
    // Register 0 writes from W take no slot, so the FIFO may use it.
    always_comb begin
        fifo_empty = (count == '0);
        wb_real    = wb_valid && (wb_addr != 5'd0);
        force_md   = !fifo_empty &&
                     ((starve == 4'(STARVE_LIMIT)) || (wb_real && wb_hit));
        wb_ready   = !force_md;
        wb_sel     = wb_real && !force_md;
        pop        = !fifo_empty && (force_md || !wb_real);
        md_ready   = (count < CW'(DEPTH));
        push       = md_valid && md_ready && (md_addr != 5'd0);
    end

    // FIFO storage; no reset needed since validity comes from the count.
    always_ff @(posedge Clk) begin
        if (push) begin
            q_addr[wr_ptr] <= md_addr;
            q_data[wr_ptr] <= md_data;
        end
    end

    // Pointers, occupancy, starvation counter and the registered write port.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            starve <= '0;
            rf_we  <= 1'b0;
            rf_a3  <= '0;
            rf_wd  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);

            if (fifo_empty || pop)
                starve <= '0;
            else if (starve != 4'(STARVE_LIMIT))
                starve <= starve + 4'd1;

            rf_we <= pop || wb_sel;
            if (pop) begin
                rf_a3 <= q_addr[rd_ptr];
                rf_wd <= q_data[rd_ptr];
            end else if (wb_sel) begin
                rf_a3 <= wb_addr;
                rf_wd <= wb_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Bench for rf_wport_arb: directed sequences push the hand-derived order of
// register file writes into a queue; a negedge monitor pops and compares
// each time rf_we is seen high. Handshake and status outputs are checked
// inline by the stimulus.
module tb_rf_wport_arb;

    logic        Clk;
    logic        Rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [4:0]  q_a1;
    logic [4:0]  q_a2;
    logic        q_busy1;
    logic        q_busy2;
    logic [1:0]  fifo_count;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    rf_wport_arb #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
        .Clk(Clk), .Rst(Rst),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .q_a1(q_a1), .q_a2(q_a2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .fifo_count(fifo_count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Drive one cycle of inputs, check the combinational handshakes, advance.
    task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] mdv,
                        input logic ewr, input logic emr);
        wb_valid = wv; wb_addr = wa; wb_data = wd;
        md_valid = mv; md_addr = ma; md_data = mdv;
        #1;
        if (wv) chk("wb_ready", wb_ready, ewr);
        chk("md_ready", md_ready, emr);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
        md_valid = 1'b0; md_addr = '0; md_data = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge Clk);
            #1;
        end
        chk("writes_outstanding", exp_q.size(), 0);
        @(posedge Clk);
        #1;
    endtask

    // Scoreboard monitor: every observed write must be the next expected one.
    initial begin
        wr_t e;
        forever begin
            @(negedge Clk);
            if (rf_we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual a3=%0d wd=%0h expected no write",
                             rf_a3, rf_wd);
                end else begin
                    e = exp_q.pop_front();
                    chk("rf_a3", rf_a3, e.a);
                    chk("rf_wd", rf_wd, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Rst = 1'b1;
        q_a1 = '0;
        q_a2 = '0;
        idle();
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_a3", rf_a3, 0);
        chk("rst_rf_wd", rf_wd, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_md_ready", md_ready, 1);
        wb_valid = 1'b1;
        #1;
        chk("rst_wb_ready", wb_ready, 1);
        wb_valid = 1'b0;
        Rst = 1'b0;
        @(posedge Clk);
        #1;

        // Reset with two entries queued
        expect_wr(5'd1, 32'h100);
        expect_wr(5'd2, 32'h101);
        step(1, 5'd1, 32'h100, 1, 5'd10, 32'hA, 1, 1);
        step(1, 5'd2, 32'h101, 1, 5'd11, 32'hB, 1, 1);
        idle();
        q_a1 = 5'd10;
        q_a2 = 5'd11;
        #1;
        chk("full_count", fifo_count, 2);
        chk("full_busy1", q_busy1, 1);
        chk("full_busy2", q_busy2, 1);
        chk("full_md_ready", md_ready, 0);
        Rst = 1'b1;
        @(posedge Clk);
        #1;
        chk("rst2_count", fifo_count, 0);
        chk("rst2_rf_we", rf_we, 0);
        chk("rst2_rf_a3", rf_a3, 0);
        chk("rst2_rf_wd", rf_wd, 0);
        chk("rst2_busy1", q_busy1, 0);
        chk("rst2_busy2", q_busy2, 0);
        Rst = 1'b0;
        drain();

        // W only, then a register-0 write that takes no slot
        expect_wr(5'd5, 32'h1234);
        step(1, 5'd5, 32'h1234, 0, 5'd0, 32'h0, 1, 1);
        chk("w_rf_we", rf_we, 1);
        chk("w_rf_a3", rf_a3, 5);
        step(1, 5'd0, 32'hFFFF, 0, 5'd0, 32'h0, 1, 1);
        chk("w0_rf_we", rf_we, 0);
        chk("w0_hold_a3", rf_a3, 5);
        chk("w0_hold_wd", rf_wd, 32'h1234);
        idle();
        drain();

        // MD drain into idle W slots, two posedges from accept
        expect_wr(5'd8, 32'hABCD);
        step(0, 5'd0, 32'h0, 1, 5'd8, 32'hABCD, 1, 1);
        idle();
        q_a1 = 5'd8;
        q_a2 = 5'd0;
        #1;
        chk("md_busy1", q_busy1, 1);
        chk("md_busy2_r0", q_busy2, 0);
        chk("md_count1", fifo_count, 1);
        chk("md_rf_we_early", rf_we, 0);
        @(posedge Clk);
        #1;
        chk("md_rf_we", rf_we, 1);
        chk("md_rf_a3", rf_a3, 8);
        chk("md_count0", fifo_count, 0);
        chk("md_busy1_clear", q_busy1, 0);
        drain();

        // MD to register 0 is dropped
        step(0, 5'd0, 32'h0, 1, 5'd0, 32'hDEAD, 1, 1);
        idle();
        #1;
        chk("md_r0_count", fifo_count, 0);
        drain();

        // Starvation: head forced after four W writes while queued
        expect_wr(5'd1, 32'h1001);
        for (int a = 2; a <= 5; a++) expect_wr(5'(a), 32'h1000 + a);
        expect_wr(5'd20, 32'h5A);
        for (int a = 6; a <= 9; a++) expect_wr(5'(a), 32'h1000 + a);
        step(1, 5'd1, 32'h1001, 1, 5'd20, 32'h5A, 1, 1);
        for (int a = 2; a <= 5; a++) step(1, 5'(a), 32'h1000 + a, 0, 5'd0, 32'h0, 1, 1);
        step(1, 5'd6, 32'h1006, 0, 5'd0, 32'h0, 0, 1);
        for (int a = 6; a <= 9; a++) step(1, 5'(a), 32'h1000 + a, 0, 5'd0, 32'h0, 1, 1);
        idle();
        drain();

        // Write-after-write conflict: older queued write goes first
        expect_wr(5'd12, 32'hC);
        expect_wr(5'd3, 32'h11);
        expect_wr(5'd3, 32'h22);
        step(1, 5'd12, 32'hC, 1, 5'd3, 32'h11, 1, 1);
        q_a1 = 5'd3;
        #1;
        chk("waw_busy1", q_busy1, 1);
        step(1, 5'd3, 32'h22, 0, 5'd0, 32'h0, 0, 1);
        step(1, 5'd3, 32'h22, 0, 5'd0, 32'h0, 1, 1);
        idle();
        drain();

        // Full FIFO, no pass-through on pop, pointer wrap over six entries
        for (int a = 1; a <= 5; a++) expect_wr(5'(a), 32'h700 + a);
        expect_wr(5'd24, 32'h601);
        expect_wr(5'd6, 32'h706);
        for (int m = 2; m <= 6; m++) expect_wr(5'(23 + m), 32'h600 + m);
        step(1, 5'd1, 32'h701, 1, 5'd24, 32'h601, 1, 1);
        step(1, 5'd2, 32'h702, 1, 5'd25, 32'h602, 1, 1);
        step(1, 5'd3, 32'h703, 1, 5'd26, 32'h603, 1, 0);
        step(1, 5'd4, 32'h704, 1, 5'd26, 32'h603, 1, 0);
        step(1, 5'd5, 32'h705, 1, 5'd26, 32'h603, 1, 0);
        step(1, 5'd6, 32'h706, 1, 5'd26, 32'h603, 0, 0);
        step(1, 5'd6, 32'h706, 1, 5'd26, 32'h603, 1, 1);
        step(0, 5'd0, 32'h0,   1, 5'd27, 32'h604, 1, 0);
        step(0, 5'd0, 32'h0,   1, 5'd27, 32'h604, 1, 1);
        step(0, 5'd0, 32'h0,   1, 5'd28, 32'h605, 1, 1);
        step(0, 5'd0, 32'h0,   1, 5'd29, 32'h606, 1, 1);
        idle();
        drain();
        chk("end_count", fifo_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
